// File: rtl/ptp_bridge_ipbb_sfw_pkt_fifo_if.sv
// Word stream bundle for the packet FIFO: valid/ready plus packet framing.
// master drives the word, slave returns ready.
interface ptp_bridge_ipbb_sfw_pkt_fifo_if #(
    parameter int DW = 8
) ();
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic          err;

    modport master (
        output valid, data, sop, eop, err,
        input  ready
    );

    modport slave (
        input  valid, data, sop, eop, err,
        output ready
    );
endinterface

// File: rtl/ptp_bridge_ipbb_sfw_pkt_fifo.sv
// Packet store-and-forward FIFO: words commit on EOP, FWFT registered output.
// PTP_BRIDGE_SFW_PKT_DROP_EN enables error/oversize/restart packet drop.
module ptp_bridge_ipbb_sfw_pkt_fifo #(
    parameter  int DW        = 8,
    parameter  int DEPTH     = 16,
    parameter  int DROP_CW   = 16,
    localparam int AW        = $clog2(DEPTH),
    localparam int MEM_DEPTH = 2**AW
) (
    input  logic                clk,
    input  logic                rst,
    ptp_bridge_ipbb_sfw_pkt_fifo_if.slave  wr,
    ptp_bridge_ipbb_sfw_pkt_fifo_if.master rd,
    output logic [AW:0]         cnt,
    output logic [AW:0]         pkt_cnt,
    output logic [DROP_CW-1:0]  drop_cnt,
    output logic                overflow
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(MEM_DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, WR_PKT, DISCARD} state_t;

    state_t state, state_n;

    logic [DW+1:0] mem [MEM_DEPTH];
    logic [DW+1:0] head;
    logic          head_vld;
    logic          run;

    logic [AW:0] wptr, cptr, rptr;
    logic [AW:0] wptr_n, cptr_n, rptr_n;
    logic [AW:0] waddr, pkt_n;

    logic          acc, pop, we, wsop, commit, full;
    logic [1:0]    drop_add;
    logic [DROP_CW:0] drop_sum;

    assign cnt      = wptr - rptr;
    assign full     = (cnt == FULL_CNT);
    assign wr.ready = run & ((state == DISCARD) | ~full);
    assign acc      = wr.valid & wr.ready;
    assign pop      = head_vld & rd.ready;
    assign rptr_n   = rptr + (AW+1)'(pop);

    assign rd.valid = head_vld;
    assign rd.data  = head[DW-1:0];
    assign rd.eop   = head[DW];
    assign rd.sop   = head[DW+1];
    assign rd.err   = 1'b0;

    // Commit and an EOP pop in the same cycle cancel out.
    assign pkt_n    = pkt_cnt + (AW+1)'(commit)
                    - (AW+1)'(pop & head[DW]);
    assign drop_sum = {1'b0, drop_cnt} + (DROP_CW+1)'(drop_add);

    always_comb begin
        state_n  = state;
        wptr_n   = wptr;
        cptr_n   = cptr;
        waddr    = wptr;
        we       = 1'b0;
        wsop     = 1'b0;
        commit   = 1'b0;
        drop_add = 2'd0;
        unique case (state)
            IDLE: if (acc) begin
                if (wr.sop) begin
                    we     = 1'b1;
                    wsop   = 1'b1;
                    wptr_n = waddr + ONE;
                    if (!wr.eop) state_n = WR_PKT;
`ifdef PTP_BRIDGE_SFW_PKT_DROP_EN
                    else if (wr.err) begin
                        wptr_n   = cptr;
                        drop_add = 2'd1;
                    end
`endif
                    else begin
                        commit = 1'b1;
                        cptr_n = wptr_n;
                    end
                end else begin
                    drop_add = 2'd1;
                    if (!wr.eop) state_n = DISCARD;
                end
            end
            WR_PKT: begin
`ifdef PTP_BRIDGE_SFW_PKT_DROP_EN
                // Full with nothing readable: the packet can never fit.
                if (full && pkt_cnt == '0) begin
                    wptr_n   = cptr;
                    drop_add = 2'd1;
                    state_n  = DISCARD;
                end else if (acc) begin
                    if (wr.sop) begin
                        waddr    = cptr;
                        drop_add = 2'd1;
                    end
                    we     = 1'b1;
                    wsop   = wr.sop;
                    wptr_n = waddr + ONE;
                    if (wr.eop) begin
                        state_n = IDLE;
                        if (wr.err) begin
                            wptr_n   = cptr;
                            drop_add = drop_add + 2'd1;
                        end else begin
                            commit = 1'b1;
                            cptr_n = wptr_n;
                        end
                    end
                end
`else
                if (acc) begin
                    we     = 1'b1;
                    wptr_n = waddr + ONE;
                    if (wr.eop) begin
                        state_n = IDLE;
                        commit  = 1'b1;
                        cptr_n  = wptr_n;
                    end
                end
`endif
            end
            DISCARD: if (acc && wr.eop) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wptr     <= '0;
            cptr     <= '0;
            rptr     <= '0;
            pkt_cnt  <= '0;
            drop_cnt <= '0;
            head     <= '0;
            head_vld <= 1'b0;
            run      <= 1'b0;
        end else begin
            state    <= state_n;
            wptr     <= wptr_n;
            cptr     <= cptr_n;
            rptr     <= rptr_n;
            pkt_cnt  <= pkt_n;
            run      <= 1'b1;
            drop_cnt <= drop_sum[DROP_CW] ? '1
                                          : drop_sum[DROP_CW-1:0];
            head_vld <= (cptr != rptr_n);
            if (cptr != rptr_n) head <= mem[rptr_n[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr[AW-1:0]] <= {wsop, wr.eop, wr.data};
    end

`ifdef PTP_BRIDGE_SFW_PKT_DROP_EN
    assign overflow = 1'b0;
`else
    logic ovf_c, ovf_d;
    logic unused_err;

    assign unused_err = wr.err;
    assign ovf_c = wr.valid & ~wr.ready & (state == WR_PKT) & full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            ovf_d    <= 1'b0;
        end else begin
            overflow <= ovf_c & ~ovf_d;
            ovf_d    <= ovf_c;
        end
    end
`endif
endmodule
